// File: rtl/sram_if_pkg.sv
// ---------------------------------------------------------------------------
// sram_if_pkg
//   Shared definitions for the SRAM-like data interface responder:
//   transfer-size encodings, the response queue entry layout, and the
//   size/address to byte-enable decoder (with misalignment detection).
// ---------------------------------------------------------------------------
package sram_if_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // One in-flight response. data/loaded capture the RAM output when the
   // entry is not answered in the cycle the RAM output is valid.
   typedef struct packed {
      logic        is_write;
      logic        err;
      logic [2:0]  wait_cnt;
      logic [31:0] data;
      logic        loaded;
   } resp_entry_t;

   typedef struct packed {
      logic [3:0] be;
      logic       err;
   } be_err_t;

   // Illegal size or misaligned half/word yields be = 0 with err set.
   function automatic be_err_t size_to_be(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      be_err_t r;
      r.be  = 4'b0000;
      r.err = 1'b0;
      case (size)
         SIZE_BYTE: r.be = 4'b0001 << addr_lo;
         SIZE_HALF: begin
            if (addr_lo[0]) r.err = 1'b1;
            else            r.be  = addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         SIZE_WORD: begin
            if (addr_lo != 2'b00) r.err = 1'b1;
            else                  r.be  = 4'b1111;
         end
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sram_byte_ram.sv
// ---------------------------------------------------------------------------
// sram_byte_ram
//   Single-port 2^ADDR_WIDTH x 32 RAM with per-byte write enables and a
//   registered read port. The read is performed whenever en_i is high.
//   Ports:
//     clk      clock
//     en_i     access enable (read always, write lanes selected by be_i)
//     be_i     byte write enables
//     addr_i   word address
//     wdata_i  write data
//     rdata_o  registered read data, valid the cycle after en_i
// ---------------------------------------------------------------------------
module sram_byte_ram #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic [3:0]            be_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [2**ADDR_WIDTH];
   logic [31:0] rdata_q;

   // No reset: contents must survive a reset of the responder.
   always_ff @(posedge clk) begin
      if (en_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//   Responder end of the core's SRAM-like data interface. Requests are
//   performed on an on-chip byte-writable RAM at acceptance and answered
//   in order, LATENCY cycles later than the earliest possible response,
//   through a QUEUE_DEPTH-entry response queue.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     data_req        request valid
//     data_wr         1 = store, 0 = load
//     data_size       00 byte, 01 half, 10 word, 11 illegal
//     data_addr       byte address (upper bits beyond the RAM alias)
//     data_wdata      lane-replicated store data
//     data_uncached   no functional effect
//     data_addr_ok    request accepted when high with data_req
//     data_data_ok    one-cycle response pulse, in acceptance order
//     data_rdata      full load word on a response, 0 otherwise
//     misaligned_o    response belongs to an illegal/misaligned request
// ---------------------------------------------------------------------------
module data_sram_responder
   import sram_if_pkg::*;
#(
   parameter int ADDR_WIDTH  = 14,
   parameter int LATENCY     = 0,
   parameter int QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic        data_uncached,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        misaligned_o
);

   localparam int         PW   = $clog2(QUEUE_DEPTH);
   localparam int         OW   = PW + 1;
   localparam logic [2:0] LAT3 = 3'(LATENCY);

   resp_entry_t   q_q [QUEUE_DEPTH];
   logic [OW-1:0] occ_q, occ_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic          last_ld_q;
   logic [PW-1:0] last_idx_q;

   be_err_t       be_err;
   logic          accept;
   logic          pop;
   resp_entry_t   head;
   logic [3:0]    ram_be;
   logic [31:0]   ram_q;

   logic          unused_ok;
   assign unused_ok = ^{data_uncached, data_addr[31:ADDR_WIDTH+2]};

   assign be_err = size_to_be(data_size, data_addr[1:0]);

   // Occupancy is the registered count only; a same-cycle pop does not
   // reopen the queue.
   assign data_addr_ok = !rst && (occ_q < OW'(QUEUE_DEPTH));
   assign accept       = data_req && data_addr_ok;

   // Any queued entry was pushed in an earlier cycle, so the head is
   // eligible as soon as its countdown has expired.
   assign head = q_q[rd_ptr_q];
   assign pop  = !rst && (occ_q != '0) && (head.wait_cnt == 3'd0);

   assign data_data_ok = pop;
   assign misaligned_o = pop && head.err;
   assign data_rdata   = (pop && !head.is_write && !head.err)
                         ? (head.loaded ? head.data : ram_q) : 32'h0;

   // Loads and erroneous requests still read, but never write.
   assign ram_be = data_wr ? be_err.be : 4'b0000;

   sram_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk     (clk),
      .en_i    (accept),
      .be_i    (ram_be),
      .addr_i  (data_addr[ADDR_WIDTH+1:2]),
      .wdata_i (data_wdata),
      .rdata_o (ram_q)
   );

   always_comb begin
      occ_d = occ_q;
      case ({accept, pop})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         last_ld_q  <= 1'b0;
         last_idx_q <= '0;
      end else begin
         occ_q      <= occ_d;
         if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
         last_ld_q  <= accept && !data_wr;
         last_idx_q <= wr_ptr_q;
      end
   end

   // Entry storage needs no reset: validity is carried by occ_q/pointers.
   // The slot of last cycle's load captures the RAM output unconditionally;
   // if it popped this cycle the capture is simply never used. It can never
   // collide with the push slot because QUEUE_DEPTH >= 2.
   always_ff @(posedge clk) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (accept && (wr_ptr_q == PW'(i))) begin
            q_q[i].is_write <= data_wr;
            q_q[i].err      <= be_err.err;
            q_q[i].wait_cnt <= LAT3;
            q_q[i].data     <= 32'h0;
            q_q[i].loaded   <= 1'b0;
         end else begin
            if (q_q[i].wait_cnt != 3'd0) q_q[i].wait_cnt <= q_q[i].wait_cnt - 3'd1;
            if (last_ld_q && (last_idx_q == PW'(i))) begin
               q_q[i].data   <= ram_q;
               q_q[i].loaded <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_sram_responder
//   Three responders (LATENCY 0, 3, 2; QUEUE_DEPTH 2) driven one at a time
//   with directed requests. Each accepted request pushes its hand-computed
//   response (cycle, rdata, misaligned) onto a scoreboard; a negedge
//   monitor pops and compares every data_data_ok it sees.
// ---------------------------------------------------------------------------
module tb_data_sram_responder;

   localparam int ND = 3;
   localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst   [ND];
   logic        req   [ND];
   logic        wr    [ND];
   logic [1:0]  sz    [ND];
   logic [31:0] addr  [ND];
   logic [31:0] wdata [ND];
   logic        aok   [ND];
   logic        dok   [ND];
   logic        mis   [ND];
   logic [31:0] rdata [ND];
   logic        unc = 1'b0;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      data_sram_responder #(
         .ADDR_WIDTH  (14),
         .LATENCY     ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
         .QUEUE_DEPTH (2)
      ) u_dut (
         .clk           (clk),
         .rst           (rst[g]),
         .data_req      (req[g]),
         .data_wr       (wr[g]),
         .data_size     (sz[g]),
         .data_addr     (addr[g]),
         .data_wdata    (wdata[g]),
         .data_uncached (unc),
         .data_addr_ok  (aok[g]),
         .data_data_ok  (dok[g]),
         .data_rdata    (rdata[g]),
         .misaligned_o  (mis[g])
      );
   end

   typedef struct {
      int          d;
      int          cyc;
      logic [31:0] rd;
      logic        mis;
   } exp_t;

   exp_t sb_q [$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   last_resp [ND] = '{default: -100};

   function automatic int lat_of(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: every response must match the scoreboard head in DUT,
   // cycle, data and error flag; idle cycles must show zero outputs.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < ND; d++) begin
         if (dok[d]) begin
            if (sb_q.size() == 0 || sb_q[0].d != d) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_resp dut%0d @cyc %0d: got data_ok=1 want none", d, cyc);
            end else begin
               e = sb_q.pop_front();
               chk($sformatf("resp_cycle dut%0d", d), cyc, e.cyc);
               chk($sformatf("resp_rdata dut%0d", d), rdata[d], e.rd);
               chk($sformatf("resp_mis dut%0d", d), {31'h0, mis[d]}, {31'h0, e.mis});
            end
         end else begin
            chk($sformatf("idle_outs dut%0d", d), rdata[d] | {31'h0, mis[d]}, 32'h0);
         end
      end
   end

   // Drive one request and hold it until accepted; t = acceptance cycle.
   task automatic issue(input int d, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic emis,
                        input bit track, output int t);
      exp_t e;
      bit   acc;
      @(posedge clk);
      #1;
      req[d] = 1'b1; wr[d] = w; sz[d] = s; addr[d] = a; wdata[d] = wd;
      acc = 1'b0;
      t   = -1;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         if (aok[d]) acc = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!acc) begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout dut%0d: got no addr_ok want accept", d);
      end else begin
         t = cyc;
         if (track) begin
            e.d   = d;
            e.cyc = (t + 1 + lat_of(d) > last_resp[d] + 1) ? t + 1 + lat_of(d) : last_resp[d] + 1;
            e.rd  = erd;
            e.mis = emis;
            last_resp[d] = e.cyc;
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic idle(input int d);
      @(posedge clk);
      #1;
      req[d] = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (sb_q.size() != 0 && k < 60) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      chk("drain_pending", sb_q.size(), 0);
      sb_q.delete();
   endtask

   initial begin
      int t0, t1, t2, tx;
      for (int d = 0; d < ND; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0; sz[d] = SW;
         addr[d] = '0; wdata[d] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("rst_addr_ok dut%0d", d), {31'h0, aok[d]}, 32'h0);
         chk($sformatf("rst_data_ok dut%0d", d), {31'h0, dok[d]}, 32'h0);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) rst[d] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < ND; d++)
         chk($sformatf("post_rst_addr_ok dut%0d", d), {31'h0, aok[d]}, 32'h1);

      // LATENCY 0: store then load to the same word, back to back
      issue(0, 1'b1, SW, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, t0);
      issue(0, 1'b0, SW, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, t1);
      idle(0);
      drain();
      chk("l0_back_to_back", t1, t0 + 1);

      // byte stores assembling a word, then word and half loads
      issue(0, 1'b1, SB, 32'h200, 32'h11111111, 32'h0, 1'b0, 1'b1, tx);
      issue(0, 1'b1, SB, 32'h201, 32'h22222222, 32'h0, 1'b0, 1'b1, tx);
      issue(0, 1'b1, SB, 32'h202, 32'h33333333, 32'h0, 1'b0, 1'b1, tx);
      issue(0, 1'b1, SB, 32'h203, 32'h44444444, 32'h0, 1'b0, 1'b1, tx);
      issue(0, 1'b0, SW, 32'h200, 32'h0, 32'h44332211, 1'b0, 1'b1, tx);
      issue(0, 1'b0, SH, 32'h202, 32'h0, 32'h44332211, 1'b0, 1'b1, tx);
      idle(0);
      drain();

      // misaligned / illegal requests: answered with error, no write
      issue(0, 1'b1, SW, 32'h300, 32'h00000000, 32'h0, 1'b0, 1'b1, tx);
      issue(0, 1'b1, SH, 32'h301, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, tx);
      issue(0, 1'b0, SW, 32'h300, 32'h0, 32'h0, 1'b0, 1'b1, tx);
      issue(0, 1'b0, SW, 32'h302, 32'h0, 32'h0, 1'b1, 1'b1, tx);
      issue(0, 1'b0, SX, 32'h100, 32'h0, 32'h0, 1'b1, 1'b1, tx);
      issue(0, 1'b1, SW, 32'h201, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, tx);
      issue(0, 1'b0, SW, 32'h200, 32'h0, 32'h44332211, 1'b0, 1'b1, tx);
      idle(0);
      drain();

      // address aliasing above the RAM size
      issue(0, 1'b1, SW, 32'h0001_0004, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, tx);
      issue(0, 1'b0, SW, 32'h0000_0004, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, tx);
      idle(0);
      drain();

      // LATENCY 3: preload, then three loads held on data_req
      issue(1, 1'b1, SW, 32'h10, 32'hA1A1A1A1, 32'h0, 1'b0, 1'b1, tx);
      issue(1, 1'b1, SW, 32'h14, 32'hB2B2B2B2, 32'h0, 1'b0, 1'b1, tx);
      issue(1, 1'b1, SW, 32'h18, 32'hC3C3C3C3, 32'h0, 1'b0, 1'b1, tx);
      idle(1);
      drain();
      issue(1, 1'b0, SW, 32'h10, 32'h0, 32'hA1A1A1A1, 1'b0, 1'b1, t0);
      issue(1, 1'b0, SW, 32'h14, 32'h0, 32'hB2B2B2B2, 1'b0, 1'b1, t1);
      issue(1, 1'b0, SW, 32'h18, 32'h0, 32'hC3C3C3C3, 1'b0, 1'b1, t2);
      idle(1);
      drain();
      chk("l3_accept_second", t1, t0 + 1);
      chk("l3_accept_third", t2, t0 + 5);

      // LATENCY 2: reset drops an in-flight load, RAM survives
      issue(2, 1'b1, SW, 32'h40, 32'h12345678, 32'h0, 1'b0, 1'b1, tx);
      idle(2);
      drain();
      issue(2, 1'b0, SW, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, tx);
      @(posedge clk);
      #1;
      req[2] = 1'b0;
      rst[2] = 1'b1;
      @(negedge clk);
      chk("midrst_addr_ok", {31'h0, aok[2]}, 32'h0);
      chk("midrst_data_ok", {31'h0, dok[2]}, 32'h0);
      @(posedge clk);
      #1;
      rst[2] = 1'b0;
      @(negedge clk);
      chk("after_midrst_addr_ok", {31'h0, aok[2]}, 32'h1);
      repeat (6) @(posedge clk);
      issue(2, 1'b0, SW, 32'h40, 32'h0, 32'h12345678, 1'b0, 1'b1, tx);
      idle(2);
      drain();

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1);
   end

endmodule
